// File: rtl/seven_segment_reader.sv
// seven_segment_reader: recovers a 4-digit BCD value from four active-low
// seven-segment buses once they have been stable for STABLE_CYCLES samples.
//   clk, rst        : clock, asynchronous active-high reset
//   hex0..hex3      : segment patterns {g..a}, active-low, hex0 = least significant
//   bcd             : captured digits {d3,d2,d1,d0}
//   digit_err       : per-digit illegal-pattern flag at capture
//   valid           : at least one capture since reset
//   update          : one-cycle pulse when a capture changes {bcd,digit_err}
module seven_segment_reader #(
  parameter int unsigned STABLE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  hex0,
  input  logic [6:0]  hex1,
  input  logic [6:0]  hex2,
  input  logic [6:0]  hex3,
  output logic [15:0] bcd,
  output logic [3:0]  digit_err,
  output logic        valid,
  output logic        update
);

  localparam int unsigned CNT_W  = 18;
  localparam int unsigned HEX_W  = 28;
  localparam int unsigned DIGITS = 4;
  localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    SETTLING = 2'd0,
    CAPTURE  = 2'd1,
    HOLD     = 2'd2
  } state_t;

  logic [HEX_W-1:0]  sync1_q, sync1_d;
  logic [HEX_W-1:0]  sync2_q, sync2_d;
  logic [HEX_W-1:0]  prev_q, prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [3:0]        digit_err_q, digit_err_d;
  logic              valid_q, valid_d;
  logic              update_q, update_d;

  logic [15:0]       dec_bcd;
  logic [3:0]        dec_err;
  logic              changed;

  // Returns {err, digit}; blank decodes to 4'hE without error.
  function automatic logic [4:0] decode_digit(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = {1'b0, 4'h0};
      7'b1111001: r = {1'b0, 4'h1};
      7'b0100100: r = {1'b0, 4'h2};
      7'b0110000: r = {1'b0, 4'h3};
      7'b0011001: r = {1'b0, 4'h4};
      7'b0010010: r = {1'b0, 4'h5};
      7'b0000010: r = {1'b0, 4'h6};
      7'b1111000: r = {1'b0, 4'h7};
      7'b0000000: r = {1'b0, 4'h8};
      7'b0010000: r = {1'b0, 4'h9};
      7'b1111111: r = {1'b0, 4'hE};
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  // Input synchronizer and previous-sample register.
  always_comb begin
    sync1_d = {hex3, hex2, hex1, hex0};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Per-digit decode of the synchronized pattern.
  always_comb begin
    dec_bcd = '0;
    dec_err = '0;
    for (int i = 0; i < DIGITS; i++) begin
      {dec_err[i], dec_bcd[i*4 +: 4]} = decode_digit(sync2_q[i*7 +: 7]);
    end
  end

  assign changed = (sync2_q != prev_q);

  // Stability counter, next state and capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    digit_err_d = digit_err_q;
    valid_d     = valid_q;
    update_d    = 1'b0;

    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_STABLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      SETTLING: begin
        // Outputs load on the edge that enters CAPTURE.
        if (!changed && (cnt_q == CNT_LAST)) begin
          state_d     = CAPTURE;
          bcd_d       = dec_bcd;
          digit_err_d = dec_err;
          valid_d     = 1'b1;
          update_d    = !valid_q || ({dec_bcd, dec_err} != {bcd_q, digit_err_q});
        end
      end
      CAPTURE: begin
        // A change arriving here is not dropped: it sends us back to settling.
        state_d = changed ? SETTLING : HOLD;
      end
      HOLD: begin
        if (changed) begin
          state_d = SETTLING;
        end
      end
      default: begin
        state_d = SETTLING;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      prev_q      <= '1;
      cnt_q       <= '0;
      state_q     <= SETTLING;
      bcd_q       <= '0;
      digit_err_q <= '0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      digit_err_q <= digit_err_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
    end
  end

  assign bcd       = bcd_q;
  assign digit_err = digit_err_q;
  assign valid     = valid_q;
  assign update    = update_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader with STABLE_CYCLES=4.
module tb_seven_segment_reader;

  localparam int unsigned S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [15:0] bcd;
  logic [3:0]  digit_err;
  logic        valid;
  logic        update;

  seven_segment_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .bcd(bcd), .digit_err(digit_err), .valid(valid), .update(update)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;

  logic [6:0] seg_tab [10];

  // Reference model state: last samples seen at the inputs, the quiet
  // count since the most recent change (or reset), and the held capture.
  logic [27:0] hist [4];
  int          quiet;
  logic        armed;
  logic [15:0] m_bcd;
  logic [3:0]  m_err;
  logic        m_valid;
  logic        m_update;
  logic [19:0] exp_q [$];

  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    if (p == 7'h7F) return {1'b0, 4'hE};
    for (int k = 0; k < 10; k++)
      if (seg_tab[k] == p) return {1'b0, 4'(k)};
    return {1'b1, 4'hF};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) hist[i] = 28'hFFFFFFF;
    quiet = 0; armed = 1'b1;
    m_bcd = '0; m_err = '0; m_valid = 1'b0; m_update = 1'b0;
    exp_q.delete();
  endtask

  // A pattern is seen as changed two edges after it is sampled; once S
  // further unchanged edges have passed, the value is captured.
  task automatic model_step();
    logic [15:0] cb;
    logic [3:0]  ce;
    logic [4:0]  d;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {hex3, hex2, hex1, hex0};
    m_update = 1'b0;
    if (hist[2] != hist[3]) begin
      quiet = 0;
      armed = 1'b1;
    end else begin
      quiet++;
      if (armed && quiet == S) begin
        for (int g = 0; g < 4; g++) begin
          d = ref_dec(hist[2][g*7 +: 7]);
          cb[g*4 +: 4] = d[3:0];
          ce[g] = d[4];
        end
        m_update = !m_valid || ({cb, ce} != {m_bcd, m_err});
        if (m_update) exp_q.push_back({cb, ce});
        m_bcd = cb; m_err = ce; m_valid = 1'b1;
        armed = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Monitor: per-cycle output check plus scoreboard pop on each update.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      total++;
      if ({bcd, digit_err, valid, update} !== {m_bcd, m_err, m_valid, m_update}) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t got bcd=%h err=%b v=%b u=%b want bcd=%h err=%b v=%b u=%b",
                 $time, bcd, digit_err, valid, update, m_bcd, m_err, m_valid, m_update);
      end
      if (update === 1'b1) begin
        upd_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_unexpected t=%0t got bcd=%h err=%b want no update", $time, bcd, digit_err);
        end else begin
          e = exp_q.pop_front();
          if ({bcd, digit_err} !== e) begin
            bad++;
            $display("FAIL scoreboard_value t=%0t got %h/%b want %h/%b", $time, bcd, digit_err, e[19:4], e[3:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic [6:0] h3, h2, h1, h0);
    hex3 = h3; hex2 = h2; hex1 = h1; hex0 = h0;
  endtask

  // Counts falling edges until update is seen; 0 means none within budget.
  task automatic wait_update(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (update === 1'b1) begin
        lat = i;
        break;
      end
    end
    #2;
  endtask

  function automatic logic [6:0] rand_pat();
    int r;
    r = $urandom_range(0, 11);
    if (r < 10) return seg_tab[r];
    if (r == 10) return 7'h7F;
    return 7'($urandom);
  endfunction

  localparam logic [6:0] Z = 7'b1000000;

  initial begin
    int lat;
    int u0;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    model_reset();
    rst = 1'b1;
    drive(Z, Z, Z, Z);
    idle(3);
    chk("reset_outputs", {12'h0, bcd, digit_err, valid, update}, 32'h0);

    // Reset release and first capture.
    u0 = upd_cnt;
    rst = 1'b0;
    wait_update(lat);
    chk("first_latency", lat, 7);
    chk("first_bcd", bcd, 16'h0000);
    chk("first_err", digit_err, 4'b0000);
    chk("first_valid", valid, 1);
    idle(8);
    chk("first_pulses", upd_cnt - u0, 1);

    // Multi-digit value.
    u0 = upd_cnt;
    drive(7'b0010000, 7'b0010010, 7'b0100100, 7'b1111000);
    wait_update(lat);
    chk("multi_latency", lat, 7);
    chk("multi_bcd", bcd, 16'h9527);
    idle(8);
    chk("multi_pulses", upd_cnt - u0, 1);

    drive(Z, Z, Z, Z);
    idle(12);
    chk("zero_bcd", bcd, 16'h0000);

    // Glitch rejection.
    u0 = upd_cnt;
    drive(Z, Z, Z, 7'b1111001);
    idle(2);
    drive(Z, Z, Z, Z);
    idle(12);
    chk("glitch_pulses", upd_cnt - u0, 0);
    chk("glitch_bcd", bcd, 16'h0000);

    // Transient long enough to capture, then restored.
    u0 = upd_cnt;
    drive(Z, Z, Z, 7'b1111001);
    idle(5);
    drive(Z, Z, Z, Z);
    idle(12);
    chk("recap_pulses", upd_cnt - u0, 2);
    chk("recap_valid", valid, 1);
    chk("recap_bcd", bcd, 16'h0000);

    // Illegal pattern then restore.
    drive(Z, Z, 7'b0000100, Z);
    wait_update(lat);
    chk("illegal_latency", lat, 7);
    chk("illegal_digit", bcd[7:4], 4'hF);
    chk("illegal_err", digit_err, 4'b0010);
    drive(Z, Z, Z, Z);
    wait_update(lat);
    chk("restore_latency", lat, 7);
    chk("restore_err", digit_err, 4'b0000);

    // Blank digits.
    drive(7'h7F, 7'h7F, 7'h7F, 7'b0110000);
    wait_update(lat);
    chk("blank_bcd", bcd, 16'hEEE3);
    chk("blank_err", digit_err, 4'b0000);

    // Reset mid-settling.
    drive(Z, 7'b0011001, Z, Z);
    idle(2);
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {12'h0, bcd, digit_err, valid, update}, 32'h0);
    idle(2);
    rst = 1'b0;
    wait_update(lat);
    chk("midreset_latency", lat, 7);
    chk("midreset_bcd", bcd, 16'h0400);

    // Randomized phase, checked by the model and scoreboard.
    for (int it = 0; it < 250; it++) begin
      logic [6:0] p [4];
      for (int g = 0; g < 4; g++)
        p[g] = ($urandom_range(0, 2) == 0) ? rand_pat() : (g == 0 ? hex0 : g == 1 ? hex1 : g == 2 ? hex2 : hex3);
      drive(p[3], p[2], p[1], p[0]);
      if ($urandom_range(0, 29) == 0) begin
        idle($urandom_range(0, 3));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      idle($urandom_range(1, 10));
    end
    idle(20);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Decodes four active-low seven-segment digit buses back into BCD digits, i.e. the inverse of the stopwatch's digit-to-segment drivers. It sits on the display side of the design: it samples the hex0..hex3 pattern lines, waits until they have been stable for a programmable window, and publishes the recovered 4-digit BCD value with per-digit error flags. The board uses it for display self-check and for exporting the displayed time to downstream logic.

## Interface
- STABLE_CYCLES, default 250000: consecutive unchanged synchronized samples required before capture; legal range 1..2^18-1.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- hex0  input  7  digit 0 (least significant) segment pattern, bit [6:0] = segments g..a, active-low.
- hex1  input  7  digit 1 pattern.
- hex2  input  7  digit 2 pattern.
- hex3  input  7  digit 3 (most significant) pattern.
- bcd  output  16  captured digits, {d3,d2,d1,d0}, 4 bits each.
- digit_err  output  4  bit i set when digit i held an illegal pattern at capture.
- valid  output  1  at least one capture has occurred since reset.
- update  output  1  one-cycle pulse when bcd or digit_err changes on a capture.

## Operation
- Input stage: the 28 hex bits pass through a 2-flop synchronizer (sync1, sync2). A third register, prev, holds the previous sync2 value.
- Decode (combinational on sync2), per digit, active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 1111111 (blank) decodes to 4'hE, which is legal and sets no error.
  - Every other pattern decodes to 4'hF and sets an error for that digit (for example 0000100).
- Stability counter cnt is 18 bits.
  - If sync2 != prev, cnt is cleared to 0 and the FSM enters SETTLING.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- FSM states:
  - SETTLING: wait for stability. When sync2 == prev and cnt == STABLE_CYCLES-1, move to CAPTURE.
  - CAPTURE (one cycle): register bcd and digit_err from the decode, set valid=1, and pulse update if the new {bcd,digit_err} differs from the held value or this is the first capture since reset. Then move to HOLD.
  - HOLD: outputs are frozen. Any change (sync2 != prev) moves back to SETTLING with cnt=0.
- While the FSM is in SETTLING, bcd, digit_err and valid keep their last captured values.
- A value that is re-captured unchanged leaves valid at 1 and produces no update pulse.
- Simultaneous change on several digits is treated as one change event.
- A change during CAPTURE is ignored for that capture and is seen on the next cycle, which returns the FSM to SETTLING.

## Timing
- Reset (asynchronous, immediate) values:
  - sync1, sync2 and prev = all 7'h7F.
  - cnt = 0, state = SETTLING.
  - bcd = 16'h0000, digit_err = 4'b0000, valid = 0, update = 0.
- Let E0 be the first clk edge that samples a new input pattern into sync1.
  - sync2 shows the new pattern after E0+1.
  - Provided the pattern stays unchanged, bcd, digit_err and update are registered at edge E0+STABLE_CYCLES+2 and visible in the following cycle.
  - update is high for exactly that one cycle.
- An input glitch lasting fewer than STABLE_CYCLES cycles never reaches bcd. It restarts the window, so the earliest capture of the final value is STABLE_CYCLES+2 edges after its own E0.
- After reset release with blank inputs held, the first capture is bcd=16'hEEEE, digit_err=0, valid=1, with one update pulse.
- Deasserting rst mid-settling restarts the FSM from SETTLING with cnt=0. No capture is carried over.

## Test plan
All tests run with STABLE_CYCLES=4.
- **Reset and first capture:** assert rst, then release with all hex inputs = 1000000. bcd=16'h0000, digit_err=0, valid rises, and update pulses exactly once in the cycle after edge E0+6.
- **Multi-digit value:** from the steady 0000 state, set hex3..hex0 = 0010000, 0010010, 0100100, 1111000. bcd=16'h9527 and update gives a single pulse, at exactly E0+6.
- **Glitch rejection:** drive hex0 to 1111001 for 2 cycles, then back to 1000000. update stays 0 and bcd is unchanged.
- **Identical re-capture:** toggle hex0 for 5 cycles, then restore it. A capture occurs for the transient value and one for the restored value. update pulses twice, and valid stays 1 throughout.
- **Illegal pattern:** set hex1=0000100. bcd[7:4]=4'hF, digit_err=4'b0010 and update pulses. Restoring hex1=1000000 then clears digit_err with another update pulse.
- **Reset mid-settling:** assert rst 2 cycles after an input change. bcd, digit_err, valid and update drop to 0 asynchronously. After release, capture occurs STABLE_CYCLES+2 edges after re-sampling.
